switch_voq_out_sched: RTL and testbench

SWITCH_VOQ_OUT_SCHED -- requirements
Module: switch_voq_out_sched

---
 rtl/switch_pkg.sv | 35 +++
 rtl/switch_axis_skid.sv | 67 ++++++
 rtl/switch_voq_out_sched.sv | 132 +++++++++++++
 tb/tb_switch_voq_out_sched.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared switch definitions: lane-index sizing, scheduler state encoding and
// round-robin lane selection reused by the output scheduler and the crossbar.
package switch_pkg;

  localparam int LANE_MAX = 32;

  typedef enum logic {
    SCHED_IDLE = 1'b0,
    SCHED_XFER = 1'b1
  } sched_state_t;

  function automatic int lane_idx_w(input int radix);
    return (radix > 1) ? $clog2(radix) : 1;
  endfunction

  // First requesting lane at or after ptr, wrapping at radix; 0 when nothing requests.
  function automatic int rr_select(input logic [LANE_MAX-1:0] req, input int ptr, input int radix);
    int   pick;
    logic found;
    logic [4:0] idx;
    pick  = 0;
    found = 1'b0;
    for (int i = 0; i < LANE_MAX; i++) begin
      if (i < radix) begin
        idx = 5'((ptr + i) % radix);
        if (!found && req[idx]) begin
          pick  = int'(idx);
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/switch_axis_skid.sv
// Two-entry AXI-Stream skid buffer: registered in_ready, one-cycle latency,
// full throughput.
module switch_axis_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             ready_q, ready_d;
  logic             out_valid_d;
  logic             temp_valid_q, temp_valid_d;
  logic [WIDTH-1:0] temp_data_q;
  logic             load_out, load_temp, temp_to_out;

  // Ready for next cycle is computed early so the upstream never sees out_ready directly.
  always_comb begin
    out_valid_d  = out_valid;
    temp_valid_d = temp_valid_q;
    load_out     = 1'b0;
    load_temp    = 1'b0;
    temp_to_out  = 1'b0;
    ready_d      = out_ready || (!temp_valid_q && (!out_valid || !in_valid));
    if (ready_q) begin
      if (out_ready || !out_valid) begin
        out_valid_d = in_valid;
        load_out    = 1'b1;
      end else begin
        temp_valid_d = in_valid;
        load_temp    = 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d  = temp_valid_q;
      temp_valid_d = 1'b0;
      temp_to_out  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q      <= 1'b0;
      out_valid    <= 1'b0;
      temp_valid_q <= 1'b0;
      out_data     <= '0;
      temp_data_q  <= '0;
    end else begin
      ready_q      <= ready_d;
      out_valid    <= out_valid_d;
      temp_valid_q <= temp_valid_d;
      if (load_out)
        out_data <= in_data;
      else if (temp_to_out)
        out_data <= temp_data_q;
      if (load_temp)
        temp_data_q <= in_data;
    end
  end

  assign in_ready = ready_q;

endmodule

// File: rtl/switch_voq_out_sched.sv
// Output-port scheduler: round-robin packet arbitration across VOQ heads,
// locking a lane until its tlast beat and forwarding through a skid buffer.
module switch_voq_out_sched
  import switch_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH  = 64,
  parameter int AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH / 8,
  parameter bit AXIS_ID_ENABLE   = 1'b1,
  parameter bit AXIS_DEST_ENABLE = 1'b1,
  parameter bit AXIS_USER_ENABLE = 1'b1,
  parameter int AXIS_ID_WIDTH    = 8,
  parameter int AXIS_USER_WIDTH  = 17,
  parameter int RADIX            = 4,
  parameter int AXIS_DEST_WIDTH  = RADIX
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [RADIX*AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [RADIX*AXIS_KEEP_WIDTH-1:0]    s_axis_tkeep,
  input  logic [RADIX-1:0]                    s_axis_tvalid,
  output logic [RADIX-1:0]                    s_axis_tready,
  input  logic [RADIX-1:0]                    s_axis_tlast,
  input  logic [RADIX*AXIS_ID_WIDTH-1:0]      s_axis_tid,
  input  logic [RADIX*AXIS_DEST_WIDTH-1:0]    s_axis_tdest,
  input  logic [RADIX*AXIS_USER_WIDTH-1:0]    s_axis_tuser,
  output logic [AXIS_DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]          m_axis_tkeep,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tlast,
  output logic [AXIS_ID_WIDTH-1:0]            m_axis_tid,
  output logic [AXIS_DEST_WIDTH-1:0]          m_axis_tdest,
  output logic [AXIS_USER_WIDTH-1:0]          m_axis_tuser,
  output logic                                grant_valid,
  output logic [lane_idx_w(RADIX)-1:0]        grant_index,
  output logic [31:0]                         stat_pkt_count
);

  localparam int IW     = lane_idx_w(RADIX);
  localparam int BEAT_W = AXIS_DATA_WIDTH + AXIS_KEEP_WIDTH + 1 + AXIS_ID_WIDTH
                        + AXIS_DEST_WIDTH + AXIS_USER_WIDTH;

  sched_state_t state, state_next;
  logic [IW-1:0] grant, grant_next, rr_ptr, rr_ptr_next;
  logic [31:0] pkt_count;
  logic [LANE_MAX-1:0] req_vec;
  logic skid_ready, lane_valid, lane_last, accept_last;
  logic [AXIS_DATA_WIDTH-1:0] lane_data;
  logic [AXIS_KEEP_WIDTH-1:0] lane_keep;
  logic [AXIS_ID_WIDTH-1:0]   lane_id;
  logic [AXIS_DEST_WIDTH-1:0] lane_dest;
  logic [AXIS_USER_WIDTH-1:0] lane_user;
  logic [BEAT_W-1:0] in_beat, out_beat;

  assign req_vec = LANE_MAX'(s_axis_tvalid);

  // Only the locked lane reaches the skid buffer; disabled sideband fields are zeroed here.
  always_comb begin
    lane_data  = s_axis_tdata[grant*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
    lane_keep  = s_axis_tkeep[grant*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
    lane_id    = AXIS_ID_ENABLE   ? s_axis_tid[grant*AXIS_ID_WIDTH +: AXIS_ID_WIDTH]         : '0;
    lane_dest  = AXIS_DEST_ENABLE ? s_axis_tdest[grant*AXIS_DEST_WIDTH +: AXIS_DEST_WIDTH]   : '0;
    lane_user  = AXIS_USER_ENABLE ? s_axis_tuser[grant*AXIS_USER_WIDTH +: AXIS_USER_WIDTH]   : '0;
    lane_last  = s_axis_tlast[grant];
    lane_valid = (state == SCHED_XFER) && s_axis_tvalid[grant];
  end

  assign accept_last = lane_valid && skid_ready && lane_last;
  assign in_beat     = {lane_data, lane_keep, lane_last, lane_id, lane_dest, lane_user};

  always_comb begin
    state_next  = state;
    grant_next  = grant;
    rr_ptr_next = rr_ptr;
    case (state)
      SCHED_IDLE: begin
        if (|s_axis_tvalid) begin
          grant_next = IW'(rr_select(req_vec, int'(rr_ptr), RADIX));
          state_next = SCHED_XFER;
        end
      end
      SCHED_XFER: begin
        if (accept_last) begin
          rr_ptr_next = (int'(grant) == RADIX - 1) ? '0 : grant + 1'b1;
          state_next  = SCHED_IDLE;
        end
      end
      default: state_next = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCHED_IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      pkt_count <= '0;
    end else begin
      state  <= state_next;
      grant  <= grant_next;
      rr_ptr <= rr_ptr_next;
      if (accept_last)
        pkt_count <= pkt_count + 32'd1;
    end
  end

  // tready depends only on registered state and the skid buffer's registered ready.
  always_comb begin
    s_axis_tready = '0;
    if (state == SCHED_XFER && skid_ready)
      s_axis_tready[grant] = 1'b1;
  end

  switch_axis_skid #(
    .WIDTH(BEAT_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_beat),
    .in_valid  (lane_valid),
    .in_ready  (skid_ready),
    .out_data  (out_beat),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser} = out_beat;
  assign grant_valid    = (state == SCHED_XFER);
  assign grant_index    = grant;
  assign stat_pkt_count = pkt_count;

endmodule

// File: tb/tb_switch_voq_out_sched.sv
// Directed bench for switch_voq_out_sched: lane sources, output capture and
// hand-derived packet/grant orders checked with immediate assertions.
module tb_switch_voq_out_sched;

  localparam int DW = 64, KW = 8, IDW = 8, UW = 17, R = 4, DSTW = R, GW = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [R*DW-1:0]   s_axis_tdata;
  logic [R*KW-1:0]   s_axis_tkeep;
  logic [R-1:0]      s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [R*IDW-1:0]  s_axis_tid;
  logic [R*DSTW-1:0] s_axis_tdest;
  logic [R*UW-1:0]   s_axis_tuser;
  logic [DW-1:0]     m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic              m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [IDW-1:0]    m_axis_tid;
  logic [DSTW-1:0]   m_axis_tdest;
  logic [UW-1:0]     m_axis_tuser;
  logic              grant_valid;
  logic [GW-1:0]     grant_index;
  logic [31:0]       stat_pkt_count;

  always #5 clk = ~clk;

  switch_voq_out_sched dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
    .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
    .grant_valid(grant_valid), .grant_index(grant_index), .stat_pkt_count(stat_pkt_count)
  );

  typedef struct {
    logic [DW-1:0]   data;
    logic            last;
    logic [IDW-1:0]  id;
    logic [DSTW-1:0] dest;
    logic [UW-1:0]   user;
    logic [KW-1:0]   keep;
  } beat_t;

  logic [DW-1:0] src_data [R][16];
  logic          src_last [R][16];
  int            src_len  [R];
  int            src_idx  [R];
  logic          hold     [R];
  beat_t         cap_q[$], exp_q[$];
  int            grant_q[$], exp_g[$];
  logic          prev_gv;
  logic          toggle_ready;
  int            n_assert = 0;
  int            n_fail = 0;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t make_beat(input int n, input int i);
    beat_t b;
    b.data = src_data[n][i];
    b.last = src_last[n][i];
    b.id   = IDW'(8'h40 + n);
    b.dest = DSTW'(1 << n);
    b.user = UW'(src_data[n][i]) ^ UW'(n << 13);
    b.keep = KW'(8'hF0 | n);
    return b;
  endfunction

  task automatic apply_stimulus();
    beat_t b;
    for (int n = 0; n < R; n++) begin
      if (src_idx[n] < src_len[n] && !hold[n]) begin
        b = make_beat(n, src_idx[n]);
        s_axis_tvalid[n] = 1'b1;
        s_axis_tlast[n]  = b.last;
        s_axis_tdata[n*DW +: DW]       = b.data;
        s_axis_tkeep[n*KW +: KW]       = b.keep;
        s_axis_tid[n*IDW +: IDW]       = b.id;
        s_axis_tdest[n*DSTW +: DSTW]   = b.dest;
        s_axis_tuser[n*UW +: UW]       = b.user;
      end else begin
        s_axis_tvalid[n] = 1'b0;
        s_axis_tlast[n]  = 1'b0;
        s_axis_tdata[n*DW +: DW]       = '0;
        s_axis_tkeep[n*KW +: KW]       = '0;
        s_axis_tid[n*IDW +: IDW]       = '0;
        s_axis_tdest[n*DSTW +: DSTW]   = '0;
        s_axis_tuser[n*UW +: UW]       = '0;
      end
    end
  endtask

  task automatic load_lane(input int n, input int base, input int count, input int pkt_len);
    for (int i = 0; i < count; i++) begin
      src_data[n][i] = DW'(base + i);
      src_last[n][i] = ((i + 1) % pkt_len == 0);
    end
    src_len[n] = count;
    src_idx[n] = 0;
  endtask

  task automatic expect_lane(input int n, input int first, input int count);
    for (int i = first; i < first + count; i++) exp_q.push_back(make_beat(n, i));
  endtask

  // One clock: sample handshakes before the edge, advance sources and capture after it.
  task automatic tick();
    logic [R-1:0] acc, allowed;
    logic m_acc, pend;
    logic [DW-1:0] pdata;
    beat_t mb;
    allowed = grant_valid ? (R'(1) << grant_index) : '0;
    check_output("tready_lane", 64'(s_axis_tready & ~allowed), 64'd0);
    acc   = s_axis_tvalid & s_axis_tready;
    m_acc = m_axis_tvalid && m_axis_tready;
    pend  = m_axis_tvalid && !m_axis_tready;
    pdata = m_axis_tdata;
    mb.data = m_axis_tdata; mb.last = m_axis_tlast; mb.id = m_axis_tid;
    mb.dest = m_axis_tdest; mb.user = m_axis_tuser; mb.keep = m_axis_tkeep;
    @(posedge clk);
    #1;
    if (pend) begin
      check_output("stall_valid", 64'(m_axis_tvalid), 64'd1);
      check_output("stall_data", m_axis_tdata, pdata);
    end
    for (int n = 0; n < R; n++) if (acc[n]) src_idx[n]++;
    if (m_acc) cap_q.push_back(mb);
    if (grant_valid && !prev_gv) grant_q.push_back(int'(grant_index));
    prev_gv = grant_valid;
    if (toggle_ready) m_axis_tready = ~m_axis_tready;
    apply_stimulus();
  endtask

  function automatic logic drained();
    logic d;
    d = !m_axis_tvalid && !grant_valid;
    for (int n = 0; n < R; n++) if (src_idx[n] < src_len[n]) d = 1'b0;
    return d;
  endfunction

  task automatic run_until_done(input string tag, input int budget);
    int c;
    c = 0;
    while (!drained() && c < budget) begin
      tick();
      c++;
    end
    check_output({tag, "_timeout"}, 64'(drained()), 64'd1);
  endtask

  task automatic compare_capture(input string tag);
    check_output({tag, "_count"}, 64'(cap_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < cap_q.size()) begin
        check_output({tag, "_data"}, cap_q[i].data, exp_q[i].data);
        check_output({tag, "_last"}, 64'(cap_q[i].last), 64'(exp_q[i].last));
        check_output({tag, "_id"},   64'(cap_q[i].id),   64'(exp_q[i].id));
        check_output({tag, "_dest"}, 64'(cap_q[i].dest), 64'(exp_q[i].dest));
        check_output({tag, "_user"}, 64'(cap_q[i].user), 64'(exp_q[i].user));
        check_output({tag, "_keep"}, 64'(cap_q[i].keep), 64'(exp_q[i].keep));
      end
    end
    check_output({tag, "_grants"}, 64'(grant_q.size()), 64'(exp_g.size()));
    for (int i = 0; i < exp_g.size(); i++)
      if (i < grant_q.size()) check_output({tag, "_grant"}, 64'(grant_q[i]), 64'(exp_g[i]));
    cap_q.delete(); exp_q.delete(); grant_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int n = 0; n < R; n++) begin
      hold[n] = 1'b0; src_len[n] = 0; src_idx[n] = 0;
    end
    toggle_ready  = 1'b0;
    m_axis_tready = 1'b1;
    apply_stimulus();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cap_q.delete(); exp_q.delete(); grant_q.delete();
    prev_gv = 1'b0;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    rst_n = 1'b0;
    for (int n = 0; n < R; n++) begin
      hold[n] = 1'b0; src_len[n] = 0; src_idx[n] = 0;
    end
    toggle_ready = 1'b0; m_axis_tready = 1'b1; prev_gv = 1'b0;
    apply_stimulus();
    #12;
    check_output("rst_m_valid", 64'(m_axis_tvalid), 64'd0);
    check_output("rst_s_ready", 64'(s_axis_tready), 64'd0);
    check_output("rst_grant_valid", 64'(grant_valid), 64'd0);
    check_output("rst_grant_index", 64'(grant_index), 64'd0);
    check_output("rst_pkt_count", 64'(stat_pkt_count), 64'd0);
    do_reset();
    tick();
    check_output("idle_no_grant", 64'(grant_valid), 64'd0);

    // Lanes 0 and 2 contend; lane 0 wins from rr_ptr 0 and streams at full rate.
    load_lane(0, 'hA0, 3, 3);
    load_lane(2, 'hC0, 3, 3);
    apply_stimulus();
    tick();
    check_output("t1_grant_valid", 64'(grant_valid), 64'd1);
    check_output("t1_grant_index", 64'(grant_index), 64'd0);
    check_output("t1_tready", 64'(s_axis_tready), 64'b0001);
    tick();
    check_output("t1_first_valid", 64'(m_axis_tvalid), 64'd1);
    check_output("t1_first_data", m_axis_tdata, 64'hA0);
    tick();
    check_output("t1_second_data", m_axis_tdata, 64'hA1);
    run_until_done("t1", 60);
    expect_lane(0, 0, 3);
    expect_lane(2, 0, 3);
    exp_g = '{0, 2};
    compare_capture("t1");
    check_output("t1_pkt_count", 64'(stat_pkt_count), 64'd2);

    // Every lane always valid with single-beat packets: strict rotation.
    do_reset();
    for (int n = 0; n < R; n++) load_lane(n, 'h100 + 16 * n, 2, 1);
    apply_stimulus();
    run_until_done("t2", 80);
    for (int k = 0; k < 2; k++)
      for (int n = 0; n < R; n++) expect_lane(n, k, 1);
    exp_g = '{0, 1, 2, 3, 0, 1, 2, 3};
    compare_capture("t2");
    check_output("t2_pkt_count", 64'(stat_pkt_count), 64'd8);

    // Lane 1 stalls mid-packet; lane 3 must wait for lane 1's tlast.
    do_reset();
    load_lane(1, 'h300, 5, 5);
    load_lane(3, 'h500, 2, 2);
    apply_stimulus();
    c = 0;
    while (src_idx[1] < 2 && c < 20) begin
      tick();
      c++;
    end
    check_output("t3_reach_gap", 64'(src_idx[1]), 64'd2);
    hold[1] = 1'b1;
    apply_stimulus();
    repeat (3) begin
      tick();
      check_output("t3_gap_grant_valid", 64'(grant_valid), 64'd1);
      check_output("t3_gap_grant_index", 64'(grant_index), 64'd1);
    end
    hold[1] = 1'b0;
    apply_stimulus();
    run_until_done("t3", 60);
    expect_lane(1, 0, 5);
    expect_lane(3, 0, 2);
    exp_g = '{1, 3};
    compare_capture("t3");

    // Output backpressure alternating every cycle over an 8-beat packet.
    do_reset();
    load_lane(2, 'h00, 8, 8);
    toggle_ready = 1'b1;
    apply_stimulus();
    run_until_done("t4", 80);
    toggle_ready  = 1'b0;
    m_axis_tready = 1'b1;
    expect_lane(2, 0, 8);
    exp_g = '{2};
    compare_capture("t4");
    check_output("t4_pkt_count", 64'(stat_pkt_count), 64'd1);

    // Reset after two of six beats forwarded, then a clean packet from lane 3.
    do_reset();
    load_lane(0, 'h600, 6, 6);
    apply_stimulus();
    c = 0;
    while (cap_q.size() < 2 && c < 20) begin
      tick();
      c++;
    end
    check_output("t5_pre_fwd", 64'(cap_q.size()), 64'd2);
    rst_n = 1'b0;
    #1;
    check_output("t5_rst_m_valid", 64'(m_axis_tvalid), 64'd0);
    check_output("t5_rst_s_ready", 64'(s_axis_tready), 64'd0);
    check_output("t5_rst_grant_valid", 64'(grant_valid), 64'd0);
    check_output("t5_rst_pkt_count", 64'(stat_pkt_count), 64'd0);
    do_reset();
    load_lane(3, 'h700, 4, 4);
    apply_stimulus();
    run_until_done("t5", 40);
    expect_lane(3, 0, 4);
    exp_g = '{3};
    compare_capture("t5");
    check_output("t5_pkt_count", 64'(stat_pkt_count), 64'd1);

    // Packet counter wraps from all-ones to zero.
    force dut.pkt_count = 32'hFFFF_FFFF;
    #1;
    release dut.pkt_count;
    check_output("t6_preset", 64'(stat_pkt_count), 64'hFFFF_FFFF);
    load_lane(1, 'h800, 1, 1);
    apply_stimulus();
    run_until_done("t6", 30);
    expect_lane(1, 0, 1);
    exp_g = '{1};
    compare_capture("t6");
    check_output("t6_wrap", 64'(stat_pkt_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
